// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: instruction field map,
// the idle instruction word and the sequencer state encoding.
package core_inst_pkg;

  localparam int unsigned InstW = 34;
  localparam int unsigned AddrW = 11;

  localparam int unsigned BitAcc     = 33;
  localparam int unsigned BitPCen    = 32;
  localparam int unsigned BitPWen    = 31;
  localparam int unsigned BitPAddrLo = 20;
  localparam int unsigned BitXCen    = 19;
  localparam int unsigned BitXWen    = 18;
  localparam int unsigned BitXAddrLo = 7;
  localparam int unsigned BitOfifoRd = 6;
  localparam int unsigned BitL0Rd    = 3;
  localparam int unsigned BitL0Wr    = 2;
  localparam int unsigned BitExec    = 1;
  localparam int unsigned BitLoad    = 0;

  // Both SRAMs disabled (CEN/WEN high), every strobe low.
  localparam logic [InstW-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    StIdle,
    StWRd,
    StKLoad,
    StKGap,
    StXRd,
    StExec,
    StORead
  } state_e;

endpackage

// File: rtl/core_inst_phase_cnt.sv
// Loadable up-counter with a terminal-count flag; one instance times every
// phase of the sequencer.
module core_inst_phase_cnt #(
  parameter int unsigned Width = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [Width-1:0] i_last,
  output logic [Width-1:0] o_cnt,
  output logic             o_tc
);

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] r_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_last <= i_last;
    end else if (i_inc) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == r_last);

endmodule

// File: rtl/core_inst_seq.sv
// Single-tile job sequencer: weight load, activation stream, execute and psum
// drain, emitted as the core's 34-bit instruction word.
module core_inst_seq
  import core_inst_pkg::*;
#(
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned LEN_BW   = 11,
  parameter int unsigned LOAD_GAP = row + col
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AddrW-1:0]  w_base,
  input  logic [AddrW-1:0]  x_base,
  input  logic [AddrW-1:0]  p_base,
  input  logic [LEN_BW-1:0] len,
  input  logic              ofifo_valid,
  output logic [InstW-1:0]  inst,
  output logic              busy,
  output logic              done
);

  // One extra bit so a phase of len+1 cycles still fits.
  localparam int unsigned CntW = LEN_BW + 1;
  localparam logic [CntW-1:0] ColC = CntW'(col);
  localparam logic [CntW-1:0] GapC = CntW'(LOAD_GAP);

  state_e            r_state, w_state_nxt;
  logic [AddrW-1:0]  r_wb, r_xb, r_pb, w_wb;
  logic [LEN_BW-1:0] r_len;
  logic [CntW-1:0]   w_cnt, w_k_nxt, w_last, w_len_c;
  logic              w_tc, w_load, w_inc, w_done_nxt;
  logic [InstW-1:0]  r_inst, w_inst_nxt;
  logic              r_busy, r_done;

  assign w_len_c = CntW'(r_len);

  core_inst_phase_cnt #(
    .Width (CntW)
  ) u_phase_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_last  (w_last),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_last      = '0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = StWRd;
            w_load      = 1'b1;
            w_last      = ColC;
          end
        end
      end
      StWRd: begin
        if (w_tc) begin
          w_state_nxt = StKLoad;
          w_load      = 1'b1;
          w_last      = ColC - CntW'(1);
        end else begin
          w_inc = 1'b1;
        end
      end
      StKLoad: begin
        if (w_tc) begin
          w_state_nxt = StKGap;
          w_load      = 1'b1;
          w_last      = GapC - CntW'(1);
        end else begin
          w_inc = 1'b1;
        end
      end
      StKGap: begin
        if (w_tc) begin
          w_state_nxt = StXRd;
          w_load      = 1'b1;
          w_last      = w_len_c;
        end else begin
          w_inc = 1'b1;
        end
      end
      StXRd: begin
        if (w_tc) begin
          w_state_nxt = StExec;
          w_load      = 1'b1;
          w_last      = w_len_c - CntW'(1);
        end else begin
          w_inc = 1'b1;
        end
      end
      StExec: begin
        if (w_tc) begin
          w_state_nxt = StORead;
          w_load      = 1'b1;
          w_last      = w_len_c - CntW'(1);
        end else begin
          w_inc = 1'b1;
        end
      end
      StORead: begin
        // The counter doubles as the psum write count here.
        if (ofifo_valid) begin
          if (w_tc) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_k_nxt = w_load ? '0 : (w_inc ? w_cnt + CntW'(1) : w_cnt);
  // On acceptance the weight base is not latched yet; take it from the port.
  assign w_wb    = (r_state == StIdle) ? w_base : r_wb;

  // Instruction for the coming cycle, built from next state and next count.
  always_comb begin
    w_inst_nxt = IDLE_INST;
    unique case (w_state_nxt)
      StWRd: begin
        if (w_k_nxt < ColC) begin
          w_inst_nxt[BitXCen]               = 1'b0;
          w_inst_nxt[BitXWen]               = 1'b1;
          w_inst_nxt[BitXAddrLo +: AddrW]   = w_wb + AddrW'(w_k_nxt);
        end
        w_inst_nxt[BitL0Wr] = (w_k_nxt != '0);
      end
      StKLoad: begin
        w_inst_nxt[BitLoad] = 1'b1;
        w_inst_nxt[BitL0Rd] = 1'b1;
      end
      StXRd: begin
        if (w_k_nxt < w_len_c) begin
          w_inst_nxt[BitXCen]             = 1'b0;
          w_inst_nxt[BitXWen]             = 1'b1;
          w_inst_nxt[BitXAddrLo +: AddrW] = r_xb + AddrW'(w_k_nxt);
        end
        w_inst_nxt[BitL0Wr] = (w_k_nxt != '0);
      end
      StExec: begin
        w_inst_nxt[BitExec] = 1'b1;
        w_inst_nxt[BitL0Rd] = 1'b1;
      end
      default: ;
    endcase
    w_inst_nxt[BitAcc] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_inst  <= IDLE_INST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wb    <= '0;
      r_xb    <= '0;
      r_pb    <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_inst  <= w_inst_nxt;
      r_busy  <= (w_state_nxt != StIdle);
      r_done  <= w_done_nxt;
      if (r_state == StIdle && start) begin
        r_wb  <= w_base;
        r_xb  <= x_base;
        r_pb  <= p_base;
        r_len <= len;
      end
    end
  end

  // The psum drain follows ofifo_valid in the same cycle.
  always_comb begin
    inst = r_inst;
    if (r_state == StORead) begin
      inst[BitOfifoRd]          = ofifo_valid;
      inst[BitPCen]             = ~ofifo_valid;
      inst[BitPWen]             = ~ofifo_valid;
      inst[BitPAddrLo +: AddrW] = ofifo_valid ? r_pb + AddrW'(w_cnt) : '0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: full jobs, OFIFO stalls, address wrap,
// empty job, mid-job start and mid-job reset.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base, p_base, len;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy, done;

  core_inst_seq #(
    .row      (8),
    .col      (8),
    .LEN_BW   (11),
    .LOAD_GAP (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .len         (len),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int xrd_addr[$], xrd_cyc[$], l0wr_cyc[$], pwr_addr[$], pwr_cyc[$];
  int load_n, exec_n, gap_idle, ordrd_n, xcen_lo, pcen_lo, done_cyc, done_n, busy_n, bad_n;
  logic [33:0] abort_inst, done_inst;
  logic        abort_busy;

  // mode 0: ofifo_valid=1; 1: OREAD pattern 1,0,0; 2: start pulse in K_GAP; 3: reset in EXEC
  task automatic run_job(input int wb, input int xb, input int pb, input int ln,
                         input int mode, input int limit);
    xrd_addr.delete(); xrd_cyc.delete(); l0wr_cyc.delete();
    pwr_addr.delete(); pwr_cyc.delete();
    load_n = 0; exec_n = 0; gap_idle = 0; ordrd_n = 0; xcen_lo = 0; pcen_lo = 0;
    done_cyc = 0; done_n = 0; busy_n = 0; bad_n = 0;
    abort_inst = '0; abort_busy = 1'b1; done_inst = '0;
    @(negedge clk);
    w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb); len = 11'(ln);
    start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (mode == 1) ofifo_valid = (c >= 43) && (((c - 43) % 3) == 0);
      else ofifo_valid = 1'b1;
      if (mode == 2 && c == 20) begin
        start = 1'b1; w_base = 11'd50; x_base = 11'd100; p_base = 11'd200; len = 11'd7;
      end
      if (mode == 2 && c == 21) start = 1'b0;
      if (mode == 3 && c == 40) reset = 1'b1;
      if (mode == 3 && c == 41) reset = 1'b0;
      @(negedge clk);
      if (inst[19] == 1'b0) begin
        xcen_lo++;
        if (inst[18]) begin
          xrd_addr.push_back(int'(inst[17:7]));
          xrd_cyc.push_back(c);
        end else bad_n++;
      end
      if (inst[2]) l0wr_cyc.push_back(c);
      if (inst[0] && inst[3]) load_n++;
      if (inst[1] && inst[3]) exec_n++;
      if (inst[6]) ordrd_n++;
      if (inst[32] == 1'b0) begin
        pcen_lo++;
        if (inst[31] == 1'b0 && inst[6]) begin
          pwr_addr.push_back(int'(inst[30:20]));
          pwr_cyc.push_back(c);
        end
      end
      if (c >= 18 && c <= 33 && inst === IDLE) gap_idle++;
      if (inst[33] || inst[5:4] != 2'b00) bad_n++;
      if (busy) busy_n++;
      if (mode == 3 && c == 41) begin
        abort_inst = inst;
        abort_busy = busy;
      end
      if (done) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc  = c;
          done_inst = inst;
        end
        break;
      end
    end
    ofifo_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (inst !== IDLE) begin n_err++; $display("FAIL reset_inst got %h want %h", inst, IDLE); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (inst !== IDLE) begin n_err++; $display("FAIL idle_inst got %h want %h", inst, IDLE); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_basic();
    int g, e;
    run_job(0, 8, 0, 4, 0, 100);
    n_vec++; if (done_cyc !== 47) begin n_err++; $display("FAIL basic_done_cyc got %0d want 47", done_cyc); end
    n_vec++; if (done_n !== 1) begin n_err++; $display("FAIL basic_done_n got %0d want 1", done_n); end
    n_vec++; if (busy_n !== 46) begin n_err++; $display("FAIL basic_busy got %0d want 46", busy_n); end
    n_vec++; if (load_n !== 8) begin n_err++; $display("FAIL basic_load got %0d want 8", load_n); end
    n_vec++; if (exec_n !== 4) begin n_err++; $display("FAIL basic_exec got %0d want 4", exec_n); end
    n_vec++; if (gap_idle !== 16) begin n_err++; $display("FAIL basic_gap got %0d want 16", gap_idle); end
    n_vec++; if (bad_n !== 0) begin n_err++; $display("FAIL basic_badbits got %0d want 0", bad_n); end
    n_vec++; if (done_inst !== IDLE) begin n_err++; $display("FAIL basic_done_inst got %h want %h", done_inst, IDLE); end
    n_vec++; if (xrd_addr.size() !== 12) begin n_err++; $display("FAIL basic_xrd_n got %0d want 12", xrd_addr.size()); end
    n_vec++; if (l0wr_cyc.size() !== 12) begin n_err++; $display("FAIL basic_l0wr_n got %0d want 12", l0wr_cyc.size()); end
    for (int i = 0; i < 12; i++) begin
      e = (i < 8) ? i + 1 : 34 + i - 8;
      g = (i < xrd_addr.size()) ? xrd_addr[i] : -1;
      n_vec++; if (g !== i) begin n_err++; $display("FAIL basic_xaddr[%0d] got %0d want %0d", i, g, i); end
      g = (i < xrd_cyc.size()) ? xrd_cyc[i] : -1;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL basic_xcyc[%0d] got %0d want %0d", i, g, e); end
      g = (i < l0wr_cyc.size()) ? l0wr_cyc[i] : -1;
      n_vec++; if (g !== e + 1) begin n_err++; $display("FAIL basic_l0wr[%0d] got %0d want %0d", i, g, e + 1); end
    end
    n_vec++; if (pwr_addr.size() !== 4) begin n_err++; $display("FAIL basic_pwr_n got %0d want 4", pwr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < pwr_addr.size()) ? pwr_addr[i] : -1;
      n_vec++; if (g !== i) begin n_err++; $display("FAIL basic_paddr[%0d] got %0d want %0d", i, g, i); end
      g = (i < pwr_cyc.size()) ? pwr_cyc[i] : -1;
      n_vec++; if (g !== 43 + i) begin n_err++; $display("FAIL basic_pcyc[%0d] got %0d want %0d", i, g, 43 + i); end
    end
  endtask

  task automatic test_ofifo_stall();
    int g;
    run_job(0, 8, 0, 4, 1, 120);
    n_vec++; if (ordrd_n !== 4) begin n_err++; $display("FAIL stall_ordrd got %0d want 4", ordrd_n); end
    n_vec++; if (pcen_lo !== 4) begin n_err++; $display("FAIL stall_pcen got %0d want 4", pcen_lo); end
    n_vec++; if (done_cyc !== 53) begin n_err++; $display("FAIL stall_done_cyc got %0d want 53", done_cyc); end
    n_vec++; if (done_n !== 1) begin n_err++; $display("FAIL stall_done_n got %0d want 1", done_n); end
    for (int i = 0; i < 4; i++) begin
      g = (i < pwr_addr.size()) ? pwr_addr[i] : -1;
      n_vec++; if (g !== i) begin n_err++; $display("FAIL stall_paddr[%0d] got %0d want %0d", i, g, i); end
      g = (i < pwr_cyc.size()) ? pwr_cyc[i] : -1;
      n_vec++; if (g !== 43 + 3 * i) begin n_err++; $display("FAIL stall_pcyc[%0d] got %0d want %0d", i, g, 43 + 3 * i); end
    end
  endtask

  task automatic test_wrap();
    int g;
    int exp_x[4] = '{2046, 2047, 0, 1};
    int exp_p[4] = '{2047, 0, 1, 2};
    run_job(0, 2046, 2047, 4, 0, 100);
    n_vec++; if (done_cyc !== 47) begin n_err++; $display("FAIL wrap_done_cyc got %0d want 47", done_cyc); end
    for (int i = 0; i < 4; i++) begin
      g = (i + 8 < xrd_addr.size()) ? xrd_addr[i + 8] : -1;
      n_vec++; if (g !== exp_x[i]) begin n_err++; $display("FAIL wrap_xaddr[%0d] got %0d want %0d", i, g, exp_x[i]); end
      g = (i < pwr_addr.size()) ? pwr_addr[i] : -1;
      n_vec++; if (g !== exp_p[i]) begin n_err++; $display("FAIL wrap_paddr[%0d] got %0d want %0d", i, g, exp_p[i]); end
    end
  endtask

  task automatic test_len0();
    run_job(0, 8, 0, 0, 0, 5);
    n_vec++; if (done_cyc !== 1) begin n_err++; $display("FAIL len0_done_cyc got %0d want 1", done_cyc); end
    n_vec++; if (xcen_lo !== 0) begin n_err++; $display("FAIL len0_xcen got %0d want 0", xcen_lo); end
    n_vec++; if (pcen_lo !== 0) begin n_err++; $display("FAIL len0_pcen got %0d want 0", pcen_lo); end
    n_vec++; if (busy_n !== 0) begin n_err++; $display("FAIL len0_busy got %0d want 0", busy_n); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL len0_done_pulse got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_busy_after got %b want 0", busy); end
  endtask

  task automatic test_start_ignored();
    int g;
    run_job(0, 8, 0, 4, 2, 100);
    n_vec++; if (done_cyc !== 47) begin n_err++; $display("FAIL ign_done_cyc got %0d want 47", done_cyc); end
    n_vec++; if (exec_n !== 4) begin n_err++; $display("FAIL ign_exec got %0d want 4", exec_n); end
    for (int i = 0; i < 4; i++) begin
      g = (i + 8 < xrd_addr.size()) ? xrd_addr[i + 8] : -1;
      n_vec++; if (g !== 8 + i) begin n_err++; $display("FAIL ign_xaddr[%0d] got %0d want %0d", i, g, 8 + i); end
      g = (i < pwr_addr.size()) ? pwr_addr[i] : -1;
      n_vec++; if (g !== i) begin n_err++; $display("FAIL ign_paddr[%0d] got %0d want %0d", i, g, i); end
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_after got %b want 0", busy); end
  endtask

  task automatic test_abort();
    run_job(0, 8, 0, 4, 3, 80);
    n_vec++; if (abort_inst !== IDLE) begin n_err++; $display("FAIL abort_inst got %h want %h", abort_inst, IDLE); end
    n_vec++; if (abort_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", abort_busy); end
    n_vec++; if (done_n !== 0) begin n_err++; $display("FAIL abort_done got %0d want 0", done_n); end
    n_vec++; if (pwr_addr.size() !== 0) begin n_err++; $display("FAIL abort_pwr got %0d want 0", pwr_addr.size()); end
    n_vec++; if (exec_n !== 2) begin n_err++; $display("FAIL abort_exec got %0d want 2", exec_n); end
  endtask

  task automatic test_back_to_back();
    int g;
    run_job(5, 8, 9, 2, 0, 100);
    n_vec++; if (done_cyc !== 41) begin n_err++; $display("FAIL b2b_done_cyc got %0d want 41", done_cyc); end
    g = (xrd_addr.size() > 0) ? xrd_addr[0] : -1;
    n_vec++; if (g !== 5) begin n_err++; $display("FAIL b2b_waddr0 got %0d want 5", g); end
    g = (xrd_addr.size() > 9) ? xrd_addr[9] : -1;
    n_vec++; if (g !== 9) begin n_err++; $display("FAIL b2b_xaddr1 got %0d want 9", g); end
    for (int i = 0; i < 2; i++) begin
      g = (i < pwr_addr.size()) ? pwr_addr[i] : -1;
      n_vec++; if (g !== 9 + i) begin n_err++; $display("FAIL b2b_paddr[%0d] got %0d want %0d", i, g, 9 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ofifo_stall();
    test_wrap();
    test_len0();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
